// File: rtl/edge_image_streamer.sv
// edge_image_streamer
//   Streams one IMG_WIDTH x IMG_HEIGHT edge image out of a BRAM as a
//   valid/ready pixel stream in raster order, one frame per start request.
//   Reads run ahead of the stream by at most two pixels. Every read lands
//   in a 2-entry FIFO, so backpressure never drops data.
//
// Ports
//   clka            clock, all logic on the rising edge
//   reset_n         asynchronous active-low reset (mid-frame reset aborts the frame)
//   start           one-cycle frame request, ignored while busy
//   busy            frame in progress
//   done            one-cycle pulse in the cycle after the last pixel transfer
//   ena/addra       BRAM read enable / address (row*IMG_WIDTH + col)
//   douta           BRAM read data, valid one cycle after ena
//   m_data/m_valid/m_ready   pixel stream handshake
//   m_sof/m_eol     first pixel of frame / last pixel of row
//
// Optional feature
//   STREAM_BORDER_ZERO_EN : outputs 0 for the one-pixel frame border.
//   Border pixels are still read and still take their normal stream slots.
module edge_image_streamer #(
  parameter int IMG_WIDTH  = 192,
  parameter int IMG_HEIGHT = 251,
  parameter int ADDR_W     = 16
) (
  input  logic              clka,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [7:0]        douta,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            inflight_q;          // read issued last cycle, data on douta now
  logic            fl_sof_q, fl_eol_q;  // tags of that in-flight read
  logic [7:0]      dat_q [2];
  logic            sof_q [2];
  logic            eol_q [2];
  logic            wptr_q, rptr_q;
  logic [1:0]      cnt_q;
  logic            done_q;

  logic            last_col, last_px, issue, pop, last_xfer;
  logic [7:0]      push_data;

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_px  = last_col && (row_q == RW'(IMG_HEIGHT - 1));

  assign m_valid  = (cnt_q != 2'd0);
  assign pop      = m_valid && m_ready;

  // Credit check: occupancy after this cycle (stored + arriving - leaving)
  // must leave room for the new read. Written without subtraction so it
  // never goes negative.
  assign issue = (state_q == RUN) &&
                 (({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  // The final pop happens once nothing is left in flight and only one
  // entry remains.
  assign last_xfer = (state_q == DRAIN) && !inflight_q && (cnt_q == 2'd1) && pop;

  assign ena   = issue;
  assign addra = ADDR_W'(row_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col_q);
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  assign m_data = m_valid ? dat_q[rptr_q] : 8'd0;
  assign m_sof  = m_valid && sof_q[rptr_q];
  assign m_eol  = m_valid && eol_q[rptr_q];

`ifdef STREAM_BORDER_ZERO_EN
  logic fl_bdr_q;
  logic border;
  assign border    = (row_q == '0) || (row_q == RW'(IMG_HEIGHT - 1)) ||
                     (col_q == '0) || last_col;
  assign push_data = fl_bdr_q ? 8'd0 : douta;
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) fl_bdr_q <= 1'b0;
    else          fl_bdr_q <= border;
  end
`else
  assign push_data = douta;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && last_px) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      fl_sof_q   <= 1'b0;
      fl_eol_q   <= 1'b0;
      dat_q[0]   <= 8'd0;
      dat_q[1]   <= 8'd0;
      sof_q[0]   <= 1'b0;
      sof_q[1]   <= 1'b0;
      eol_q[0]   <= 1'b0;
      eol_q[1]   <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= last_xfer;
      inflight_q <= issue;
      fl_sof_q   <= (row_q == '0) && (col_q == '0);
      fl_eol_q   <= last_col;
      // Raster counters advance per issued read and wrap to (0,0) after
      // the last pixel, so the next frame starts at the origin.
      if (issue) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_px ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (inflight_q) begin
        dat_q[wptr_q] <= push_data;
        sof_q[wptr_q] <= fl_sof_q;
        eol_q[wptr_q] <= fl_eol_q;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_edge_image_streamer.sv
module tb_edge_image_streamer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clka = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, ena;
  logic [15:0] addra;
  logic [7:0]  douta = 8'd0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sof, m_eol;

  edge_image_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(16)) dut (
    .clka(clka), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .ena(ena), .addra(addra), .douta(douta), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol)
  );

  always #5 clka = ~clka;

  logic [7:0] mem [0:15];
  always @(posedge clka) if (ena) douta <= mem[addra[3:0]];

  int errors = 0, checks = 0;
  int cyc = 0;
  int xfers, dones, reads, exp_idx, first_cyc, last_cyc, done_cyc;
  int s;
  logic       stalled_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sof, prev_eol;

  always @(posedge clka) cyc++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_px(int i);
`ifdef STREAM_BORDER_ZERO_EN
    if ((i / W) == 0 || (i / W) == H - 1 || (i % W) == 0 || (i % W) == W - 1)
      return 8'd0;
`endif
    return mem[i];
  endfunction

  always @(negedge clka) begin
    if (reset_n) begin
      if (stalled_prev) begin
        chk("stall_valid", 32'(m_valid), 32'(1'b1));
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_sof", 32'(m_sof), 32'(prev_sof));
        chk("stall_eol", 32'(m_eol), 32'(prev_eol));
      end
      if (m_valid && m_ready) begin
        chk("xfer_count_ok", 32'(exp_idx < N), 32'd1);
        if (exp_idx < N) begin
          chk("pix_data", 32'(m_data), 32'(exp_px(exp_idx)));
          chk("pix_sof", 32'(m_sof), 32'(exp_idx == 0));
          chk("pix_eol", 32'(m_eol), 32'((exp_idx % W) == W - 1));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        exp_idx++;
        xfers++;
      end
      stalled_prev = m_valid && !m_ready;
      prev_data = m_data; prev_sof = m_sof; prev_eol = m_eol;
      if (done) begin dones++; done_cyc = cyc; end
      if (ena) reads++;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic clear_counts();
    xfers = 0; dones = 0; reads = 0; exp_idx = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start();
    clear_counts();
    #1 start = 1'b1; s = cyc;
    @(posedge clka); #1 start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin @(posedge clka); n++; end
    chk("done_timeout", 32'(dones > 0), 32'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ena"}, 32'(ena), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_sof"}, 32'(m_sof), 32'd0);
    chk({tag, "_eol"}, 32'(m_eol), 32'd0);
    chk({tag, "_addra"}, 32'(addra), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
  endtask

  initial begin
    int k, n;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    clear_counts();

    #3 check_reset_outputs("rst");
    @(posedge clka); #1 reset_n = 1'b1;
    @(posedge clka);

    pulse_start();
    wait_done(60);
    chk("a_xfers", 32'(xfers), 32'(N));
    chk("a_first_valid_cyc", 32'(first_cyc), 32'(s + 3));
    chk("a_last_cyc", 32'(last_cyc), 32'(s + 2 + N));
    chk("a_done_cyc", 32'(done_cyc), 32'(s + 3 + N));
    chk("a_reads", 32'(reads), 32'(N));
    repeat (3) @(posedge clka);
    chk("a_one_done", 32'(dones), 32'd1);
    chk("a_idle", 32'(busy), 32'd0);

    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(1, 255));
    @(posedge clka);
    pulse_start();
    k = 0;
    while (dones == 0 && k < 200) begin
      m_ready = pat[k % 4];
      @(posedge clka); #1; k++;
    end
    m_ready = 1'b1;
    chk("b_done_seen", 32'(dones > 0), 32'd1);
    chk("b_xfers", 32'(xfers), 32'(N));
    chk("b_one_done", 32'(dones), 32'd1);

    mem[0] = 8'd0;
    @(posedge clka); #1 m_ready = 1'b0;
    pulse_start();
    repeat (20) @(posedge clka);
    @(negedge clka);
    chk("c_reads_le2", 32'(reads <= 2), 32'd1);
    chk("c_valid_held", 32'(m_valid), 32'd1);
    chk("c_data_head", 32'(m_data), 32'(exp_px(0)));
    chk("c_sof_head", 32'(m_sof), 32'd1);
    @(posedge clka); #1 m_ready = 1'b1;
    wait_done(60);
    chk("c_xfers", 32'(xfers), 32'(N));

    @(posedge clka);
    pulse_start();
    n = 0;
    while (xfers < 5 && n < 40) begin @(posedge clka); n++; end
    chk("d_reached5", 32'(xfers >= 5), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("d_rst");
    repeat (3) @(posedge clka);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clka);
    chk("d_no_done", 32'(dones), 32'd0);
    chk("d_idle", 32'(busy), 32'd0);
    pulse_start();
    wait_done(60);
    chk("d_restart_xfers", 32'(xfers), 32'(N));
    chk("d_restart_first", 32'(first_cyc), 32'(s + 3));

    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge clka);
    pulse_start();
    repeat (2) @(posedge clka);
    #1 start = 1'b1; @(posedge clka); #1 start = 1'b0;
    repeat (8) @(posedge clka);
    #1 start = 1'b1; @(posedge clka); #1 start = 1'b0;
    wait_done(60);
    repeat (6) @(posedge clka);
    chk("e_xfers", 32'(xfers), 32'(N));
    chk("e_one_done", 32'(dones), 32'd1);
    chk("e_idle", 32'(busy), 32'd0);

    pulse_start();
    wait_done(60);
    clear_counts();
    #1 start = 1'b1; s = cyc;
    @(posedge clka); #1 start = 1'b0;
    wait_done(60);
    chk("f_xfers", 32'(xfers), 32'(N));
    chk("f_first", 32'(first_cyc), 32'(s + 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
